// File: rtl/sub_seq_param.sv
// Digit-serial subtractor: {o_b, o_d} = i_a - i_b - i_bin, BW_DIGIT bits per clock, LSB slice first.
// Optional macro SUB_SEQ_OVF_EN adds o_ovf, the signed overflow of the subtraction.
module sub_seq_param #(
  parameter int BW_DATA  = 8,
  parameter int BW_DIGIT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_bin,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [BW_DATA-1:0] o_d,
  output logic               o_b,
  output logic               o_valid,
  input  logic               i_ready
`ifdef SUB_SEQ_OVF_EN
  ,
  output logic               o_ovf
`endif
);

  localparam int NUM_DIGIT = BW_DATA / BW_DIGIT;
  localparam int CNT_W     = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGIT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One slice: zero-extended subtract, top bit is the borrow out.
  function automatic logic [BW_DIGIT:0] sub_slice(
    input logic [BW_DIGIT-1:0] a,
    input logic [BW_DIGIT-1:0] b,
    input logic                bin
  );
    sub_slice = {1'b0, a} - {1'b0, b} - {{BW_DIGIT{1'b0}}, bin};
  endfunction

  logic [1:0]          r_state;
  logic [BW_DATA-1:0]  r_a;
  logic [BW_DATA-1:0]  r_b;
  logic                r_bc;
  logic [CNT_W-1:0]    r_cnt;
  logic [BW_DATA-1:0]  r_d;
  logic                r_bout;
  logic                r_ready;
  logic                r_valid;

  logic [BW_DIGIT:0]   w_slice;
  logic [BW_DIGIT-1:0] w_d;
  logic                w_bout;
  logic [BW_DATA-1:0]  w_a_next;

  assign w_slice = sub_slice(r_a[BW_DIGIT-1:0], r_b[BW_DIGIT-1:0], r_bc);
  assign w_d     = w_slice[BW_DIGIT-1:0];
  assign w_bout  = w_slice[BW_DIGIT];

  // r_a doubles as the difference accumulator: consumed slices leave at the
  // bottom while result slices enter at the top, so after NUM_DIGIT steps it holds o_d.
  generate
    if (NUM_DIGIT > 1) begin : g_multi
      assign w_a_next = {w_d, r_a[BW_DATA-1:BW_DIGIT]};
    end else begin : g_single
      assign w_a_next = w_d;
    end
  endgenerate

`ifdef SUB_SEQ_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // Valid only on the last step, where the low slice of r_a/r_b holds the operand MSBs.
  assign w_ovf = (r_a[BW_DIGIT-1] ^ r_b[BW_DIGIT-1]) & (r_a[BW_DIGIT-1] ^ w_d[BW_DIGIT-1]);
  assign o_ovf = r_ovf;
`endif

  // Handshake FSM and slice-serial datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= {BW_DATA{1'b0}};
      r_b     <= {BW_DATA{1'b0}};
      r_bc    <= 1'b0;
      r_cnt   <= CNT_ZERO;
      r_d     <= {BW_DATA{1'b0}};
      r_bout  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid && r_ready) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_bc    <= i_bin;
            r_cnt   <= CNT_ZERO;
            r_ready <= 1'b0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_a  <= w_a_next;
          r_b  <= r_b >> BW_DIGIT;
          r_bc <= w_bout;
          if (r_cnt == CNT_LAST) begin
            r_d     <= w_a_next;
            r_bout  <= w_bout;
`ifdef SUB_SEQ_OVF_EN
            r_ovf   <= w_ovf;
`endif
            r_cnt   <= CNT_ZERO;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_d     = r_d;
  assign o_b     = r_bout;

endmodule
